// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - sequential unsigned fixed-point multiplier (integer x 1.FRACTION_WIDTH ratio)
module fp_mul #(
  parameter int INT_WIDTH      = 32,
  parameter int FRACTION_WIDTH = 10,
  parameter int BITS_PER_CYCLE = 2,
  parameter int ROUND          = 0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [INT_WIDTH-1:0]      multiplicand_in,
  input  logic [FRACTION_WIDTH:0]   multiplier_in,
  input  logic                      valid_in,
  output logic [INT_WIDTH:0]        product_out,
  output logic                      valid_out,
  output logic                      busy
);

  // Iterations needed to consume all FRACTION_WIDTH+1 multiplier bits.
  localparam int N     = (FRACTION_WIDTH + BITS_PER_CYCLE) / BITS_PER_CYCLE;
  // Multiplier register padded to a whole number of digits; pad bits are zero.
  localparam int MW    = N * BITS_PER_CYCLE;
  // One extra bit when rounding so the round constant can never wrap the sum.
  localparam int ACC_W = INT_WIDTH + FRACTION_WIDTH + 1 + ROUND;
  localparam int OUT_W = INT_WIDTH + 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [ACC_W-1:0] RND_C =
    (ROUND != 0) ? (ACC_W'(1) << (FRACTION_WIDTH - 1)) : '0;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [MW-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] prod_q, prod_d;

  // Accept / iterate / finish sequencing and the shift-add datapath.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    prod_d   = prod_q;
    valid_d  = 1'b0;
    if (!busy_q) begin
      if (valid_in) begin
        mcand_d  = ACC_W'(multiplicand_in);
        mplier_d = MW'(multiplier_in);
        acc_d    = '0;
        cnt_d    = '0;
        busy_d   = 1'b1;
      end
    end else if (cnt_q != CNT_W'(N)) begin
      // Bits shifted out of mcand_q only ever meet zero multiplier bits.
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
        if (mplier_q[b]) begin
          acc_d = acc_d + (mcand_q << b);
        end
      end
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      prod_d  = OUT_W'((acc_q + RND_C) >> FRACTION_WIDTH);
      valid_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      prod_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      prod_q   <= prod_d;
    end
  end

  assign product_out = prod_q;
  assign valid_out   = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fp_mul.sv
// tb/tb_fp_mul.sv - bench for fp_mul across ROUND and BITS_PER_CYCLE variants
module tb_fp_mul;

  localparam int ND = 5;
  // Variants: 0 default, 1 rounding, 2..4 digit-width sweep.
  localparam int NS [ND] = '{6, 6, 11, 4, 1};
  localparam int RS [ND] = '{0, 1, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mc  = '0;
  logic [10:0] mp  = '0;
  logic        vin = 1'b0;
  logic [32:0] prod [ND];
  logic        vout [ND];
  logic        bsy  [ND];

  int total = 0;
  int bad   = 0;

  bit          m_busy  [ND];
  int          m_cnt   [ND];
  bit          m_valid [ND];
  bit [32:0]   m_prod  [ND];
  bit [32:0]   m_pend  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fp_mul #(
      .INT_WIDTH(32),
      .FRACTION_WIDTH(10),
      .BITS_PER_CYCLE(g < 2 ? 2 : (g == 2 ? 1 : (g == 3 ? 3 : 11))),
      .ROUND(g == 1 ? 1 : 0)
    ) u_dut (
      .clk_in(clk),
      .rst_in(rst),
      .multiplicand_in(mc),
      .multiplier_in(mp),
      .valid_in(vin),
      .product_out(prod[g]),
      .valid_out(vout[g]),
      .busy(bsy[g])
    );
  end

  function automatic longint unsigned model_mul(longint unsigned a, longint unsigned b, int r);
    return (a * b + (r != 0 ? 64'd512 : 64'd0)) >> 10;
  endfunction

  task automatic check(string name, int k, longint unsigned got, longint unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", name, k, got, want, $time);
    end
  endtask

  // Transaction-level model: each variant is busy N+1 cycles after an accept.
  initial forever begin
    @(posedge clk or posedge rst);
    for (int k = 0; k < ND; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_prod[k] = '0;
      end else if (m_busy[k]) begin
        m_valid[k] = 0;
        m_cnt[k]   = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          m_busy[k]  = 0;
          m_valid[k] = 1;
          m_prod[k]  = m_pend[k];
        end
      end else begin
        m_valid[k] = 0;
        if (vin) begin
          m_busy[k] = 1;
          m_cnt[k]  = NS[k] + 1;
          m_pend[k] = 33'(model_mul(mc, mp, RS[k]));
        end
      end
    end
  end

  // Every-cycle comparison of all variants against the model.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check("valid_out", k, vout[k], m_valid[k]);
      check("busy", k, bsy[k], m_busy[k]);
      check("product", k, prod[k], m_prod[k]);
    end
  end

  // One isolated operation: checks per-variant latency and final products.
  task automatic run_op(input logic [31:0] a, input logic [10:0] b,
                        input longint unsigned e0, input longint unsigned e1);
    int lat [ND];
    @(posedge clk); #1;
    mc = a; mp = b; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    for (int k = 0; k < ND; k++) lat[k] = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) if (vout[k] && lat[k] == 0) lat[k] = c;
    end
    for (int k = 0; k < ND; k++) begin
      check("latency", k, lat[k], NS[k] + 1);
      check("result", k, prod[k], (k == 1) ? e1 : e0);
    end
  endtask

  initial begin
    automatic int nv;
    automatic logic [31:0] ra;
    automatic logic [10:0] rb;
    check("model_half_trunc", 0, model_mul(1001, 512, 0), 500);
    check("model_half_round", 1, model_mul(1001, 512, 1), 501);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      check("reset_busy", k, bsy[k], 0);
      check("reset_product", k, prod[k], 0);
    end
    rst = 1'b0;

    run_op(32'd1000, 11'd1024, 1000, 1000);
    run_op(32'd1001, 11'd512, 500, 501);
    run_op(32'd3, 11'd1, 0, 0);
    run_op(32'hFFFF_FFFF, 11'd2047, 64'd8585740286, 64'd8585740286);
    run_op(32'd0, 11'd2047, 0, 0);

    // valid_in held high with operands changing every cycle.
    @(posedge clk); #1;
    vin = 1'b1;
    for (int c = 0; c < 40; c++) begin
      mc = $urandom(); mp = 11'($urandom_range(0, 2047));
      @(posedge clk); #1;
    end
    vin = 1'b0;
    repeat (14) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    mc = 32'd1000; mp = 11'd1024; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) begin
      check("async_busy", k, bsy[k], 0);
      check("async_product", k, prod[k], 0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    repeat (12) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) if (vout[k]) nv++;
    end
    check("no_valid_after_reset", 0, nv, 0);
    run_op(32'd7, 11'd2047, 13, 14);

    // Random operands for the sweep.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom(); rb = 11'($urandom_range(0, 2047));
      run_op(ra, rb, model_mul(ra, rb, 0), model_mul(ra, rb, 1));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fp_mul.md
Name: fp_mul

Overview:
- Sequential unsigned fixed-point multiplier; the inverse companion to the team's multi-cycle divider.
- Takes an integer operand and a fixed-point ratio in the divider's output format (1 integer bit, FRACTION_WIDTH fraction bits).
- Returns the scaled integer product, e.g. it re-applies a computed pitch/period ratio to a sample count.
- Multi-cycle shift-add core with the same valid_in/busy/valid_out handshake as the divider, so the two chain directly.

Parameters:
- INT_WIDTH, 32: width of the integer multiplicand.
- FRACTION_WIDTH, 10: fraction bits of the multiplier; the multiplier is FRACTION_WIDTH+1 bits wide.
- BITS_PER_CYCLE, 2: multiplier bits consumed per iteration, range 1..FRACTION_WIDTH+1.
- ROUND, 0: 0 truncates the product; 1 rounds half-up, adding 2^(FRACTION_WIDTH-1) before the final shift.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous active-high reset.
- multiplicand_in  input  INT_WIDTH  unsigned integer operand.
- multiplier_in  input  FRACTION_WIDTH+1  unsigned fixed-point operand; value = multiplier_in / 2^FRACTION_WIDTH.
- valid_in  input  1  operands valid this cycle.
- product_out  output  INT_WIDTH+1  (multiplicand*multiplier) >> FRACTION_WIDTH, truncated or rounded per ROUND.
- valid_out  output  1  one-cycle strobe; product_out is valid in that cycle.
- busy  output  1  operation in flight; valid_in is ignored while high.

Behaviour:
- One clock: clk_in. Reset is asynchronous and active-high on rst_in.
- Reset values: product_out=0, valid_out=0, busy=0. Internal accumulator, operand registers and iteration counter also clear to 0.
- Iteration count: N = ceil((FRACTION_WIDTH+1)/BITS_PER_CYCLE). Default N=6.
- Accept: start = valid_in && !busy, sampled at a rising edge (call it edge 0). At edge 0:
  - latch both operands;
  - clear the accumulator;
  - set busy=1;
  - set the iteration counter to 0.
- Iterate (edges 1..N), LSB-first:
  - accumulator += shifted multiplicand * (low BITS_PER_CYCLE bits of the multiplier register);
  - multiplicand register shifts left by BITS_PER_CYCLE;
  - multiplier register shifts right by BITS_PER_CYCLE;
  - on the last iteration, only the remaining bits are used; bits beyond FRACTION_WIDTH are zero.
- Accumulator width is INT_WIDTH+FRACTION_WIDTH+1 bits (with ROUND=1, add 1 bit internally). It never wraps.
- Finish (edge N+1):
  - product_out <= accumulator (plus round constant if ROUND=1) >> FRACTION_WIDTH;
  - valid_out=1 for exactly the following cycle;
  - busy=0 at the same edge.
- Latency: valid_out is high in the cycle after edge N+1, i.e. 7 edges after accept by default.
- Throughput: one operation per N+2 cycles. valid_in may be asserted in the same cycle valid_out is high (busy is already low); that cycle is a legal accept.
- product_out holds its value until the next completion. It changes only at a finish edge.
- valid_in while busy=1: ignored, with no effect on state. The upstream block must hold or retry.
- Output range:
  - multiplier < 2, so the product fits in INT_WIDTH+1 bits; no saturation is needed.
  - With ROUND=1, the largest operands still fit: the rounding carry cannot exceed the bound.
- Zero operands produce product 0 with normal latency. There is no error output.
- Reset mid-operation: rst_in asserts immediately, without waiting for a clock.
  - busy, valid_out and product_out are forced to 0.
  - The in-flight operation is discarded; no valid_out is produced after reset releases.

Test Plan:
- Identity (defaults): multiplicand=1000, multiplier=1024 (1.0), one-cycle valid_in pulse -> busy high for 7 cycles; valid_out one cycle, exactly 7 edges after the accept edge; product_out=1000.
- Truncate vs round: multiplicand=1001, multiplier=512 (0.5) -> product_out=500 with ROUND=0, 501 with ROUND=1. multiplicand=3, multiplier=1 -> 0 with either ROUND setting.
- Maximum operands: multiplicand=2^32-1, multiplier=2047 -> product_out=8585740286 with both ROUND settings, no overflow of 33 bits.
- Handshake: valid_in held high continuously with operands changing every cycle -> accepts occur only when busy=0, including in the valid_out cycle. Each result matches the operands sampled at its accept edge, one result per 8 cycles. Inputs presented while busy produce no results.
- Reset mid-operation: accept 1000×1024, assert rst_in asynchronously 3 cycles later for 2 cycles -> outputs go 0 immediately with no valid_out afterwards. The next accepted 7×2048 (multiplier 2047 used: 7×2047) -> 13.
- Parameter sweep: BITS_PER_CYCLE = 1, 3, 11 -> latency N+1 edges with N = 11, 4, 1. Random operands match the reference model (a*b)>>10.
